shift_r_seq: RTL and testbench

- Multi-cycle, area-lean right shifter, one bit per clock.
- Upstream producer of the shifted word and carry flag consumed by ALU flag/writeback logic.
- Carry-flag semantics equal the combinational right-shift CF path: shift 0 keeps cf_i; shift k>0 gives word_i[k-1].
- Used where a full barrel shifter is too large; valid/ready handshake on both sides.

---
 rtl/shift_pkg.sv | 27 ++
 rtl/shift_r_step.sv | 41 ++++
 rtl/shift_r_seq.sv | 120 ++++++++++++
 tb/tb_shift_r_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_pkg
//  Purpose  : Shared types for the sequential right shifter. Holds the
//             shift-mode encoding used by the shifter's requesters and the
//             shifter's control state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package shift_pkg;

  // Shift-mode encoding seen on the mode_i port.
  typedef enum logic [1:0] {
    LSR = 2'd0,  // logical: fill with 0
    ASR = 2'd1,  // arithmetic: replicate MSB
    ROR = 2'd2,  // rotate: LSB wraps to MSB
    RCR = 2'd3   // rotate through carry: cf enters MSB
  } shift_mode_t;

  // Control states of the sequential shifter.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_r_seq_state_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_r_step.sv
`default_nettype none
// ============================================================================
//  Module   : shift_r_step
//  Purpose  : Combinational single-bit right step. The outgoing LSB always
//             becomes the new carry; the vacated MSB is filled according to
//             the shift mode.
//  Ports    : word_i  - current word          word_o - word after one step
//             cf_i    - current carry         cf_o   - carry after one step
//             mode_i  - shift mode
//  Revision : 1.0  initial release
// ============================================================================
module shift_r_step
  import shift_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  logic [WORD_WIDTH-1:0] word_i,
  input  logic                  cf_i,
  input  shift_mode_t           mode_i,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic                  cf_o
);

  logic w_fill;

  always_comb begin
    w_fill = 1'b0;
    case (mode_i)
      LSR:     w_fill = 1'b0;
      ASR:     w_fill = word_i[WORD_WIDTH-1];
      ROR:     w_fill = word_i[0];
      RCR:     w_fill = cf_i;
      default: w_fill = 1'b0;
    endcase
  end

  assign word_o = {w_fill, word_i[WORD_WIDTH-1:1]};
  assign cf_o   = word_i[0];

endmodule : shift_r_step
`default_nettype wire

// File: rtl/shift_r_seq.sv
`default_nettype none
// ============================================================================
//  Module   : shift_r_seq
//  Purpose  : Multi-cycle right shifter, one bit per clock, with valid/ready
//             handshakes on request and result sides. Shift amount N gives
//             a result N edges after the acceptance edge; N=0 passes the
//             operand and incoming carry straight through.
//  Ports    : clk_i, rst_i (sync, active-high)
//             valid_i/ready_o, word_i, cf_i, shift_size_i, mode_i  - request
//             valid_o/ready_i, word_o, cf_o                        - result
//  Revision : 1.0  initial release
// ============================================================================
module shift_r_seq
  import shift_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [WORD_WIDTH-1:0]         word_i,
  input  logic                          cf_i,
  input  logic [$clog2(WORD_WIDTH)-1:0] shift_size_i,
  input  logic [1:0]                    mode_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [WORD_WIDTH-1:0]         word_o,
  output logic                          cf_o
);

  localparam int CNT_W = $clog2(WORD_WIDTH);

  shift_r_seq_state_t    r_state;
  shift_r_seq_state_t    w_state_nxt;
  logic [WORD_WIDTH-1:0] r_word;
  logic                  r_cf;
  shift_mode_t           r_mode;
  logic [CNT_W-1:0]      r_cnt;
  logic [WORD_WIDTH-1:0] w_step_word;
  logic                  w_step_cf;

  shift_r_step #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_step (
    .word_i (r_word),
    .cf_i   (r_cf),
    .mode_i (r_mode),
    .word_o (w_step_word),
    .cf_o   (w_step_cf)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (valid_i) begin
          w_state_nxt = (shift_size_i == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // Counter still holds the remaining steps including this one.
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (ready_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture in IDLE, one step per edge in SHIFT, hold
  // otherwise so the result is stable under backpressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_word <= '0;
      r_cf   <= 1'b0;
      r_mode <= LSR;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            r_word <= word_i;
            r_cf   <= cf_i;
            r_mode <= shift_mode_t'(mode_i);
            r_cnt  <= shift_size_i;
          end
        end
        SHIFT: begin
          r_word <= w_step_word;
          r_cf   <= w_step_cf;
          r_cnt  <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign ready_o = (r_state == IDLE);
  assign valid_o = (r_state == DONE);
  assign word_o  = r_word;
  assign cf_o    = r_cf;

endmodule : shift_r_seq
`default_nettype wire

// File: tb/tb_shift_r_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_r_seq
//  Purpose  : Self-checking bench for shift_r_seq (WORD_WIDTH=8): directed
//             vector table plus hand-written backpressure and reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_r_seq;
  import shift_pkg::*;

  localparam int W  = 8;
  localparam int SW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  word_i;
  logic          cf_i;
  logic [SW-1:0] shift_size_i;
  logic [1:0]    mode_i;
  logic          valid_o;
  logic          ready_i;
  logic [W-1:0]  word_o;
  logic          cf_o;

  int checks   = 0;
  int failures = 0;

  shift_r_seq #(
    .WORD_WIDTH (W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .word_i       (word_i),
    .cf_i         (cf_i),
    .shift_size_i (shift_size_i),
    .mode_i       (mode_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .word_o       (word_o),
    .cf_o         (cf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] word;
    logic       cf;
    logic [2:0] sh;
    logic [7:0] exp_word;
    logic       exp_cf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request at the next negedge, check latency, result and release.
  task automatic run_op(input vec_t v, input int idx);
    @(negedge clk);
    valid_i      = 1'b1;
    word_i       = v.word;
    cf_i         = v.cf;
    mode_i       = v.mode;
    shift_size_i = v.sh;
    ready_i      = 1'b0;
    @(posedge clk);                 // acceptance edge (edge 0)
    @(negedge clk);
    valid_i = 1'b0;
    word_i  = '0;
    cf_i    = 1'b0;
    for (int k = 0; k < int'(v.sh); k++) begin
      chk($sformatf("v%0d_busy_valid_k%0d", idx, k), 32'(valid_o), 32'd0);
      chk($sformatf("v%0d_busy_ready_k%0d", idx, k), 32'(ready_o), 32'd0);
      @(negedge clk);
    end
    chk($sformatf("v%0d_valid", idx), 32'(valid_o), 32'd1);
    chk($sformatf("v%0d_word", idx), 32'(word_o), 32'(v.exp_word));
    chk($sformatf("v%0d_cf", idx), 32'(cf_o), 32'(v.exp_cf));
    chk($sformatf("v%0d_ready_in_done", idx), 32'(ready_o), 32'd0);
    ready_i = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_idle_ready", idx), 32'(ready_o), 32'd1);
    chk($sformatf("v%0d_idle_valid", idx), 32'(valid_o), 32'd0);
    ready_i = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{LSR, 8'hB5, 1'b0, 3'd3, 8'h16, 1'b1};
    vecs[1]  = '{ASR, 8'hB5, 1'b0, 3'd3, 8'hF6, 1'b1};
    vecs[2]  = '{ROR, 8'hB5, 1'b0, 3'd3, 8'hB6, 1'b1};
    vecs[3]  = '{RCR, 8'hB5, 1'b0, 3'd1, 8'h5A, 1'b1};
    vecs[4]  = '{LSR, 8'h3C, 1'b1, 3'd0, 8'h3C, 1'b1};
    vecs[5]  = '{ASR, 8'h3C, 1'b1, 3'd0, 8'h3C, 1'b1};
    vecs[6]  = '{ROR, 8'h3C, 1'b1, 3'd0, 8'h3C, 1'b1};
    vecs[7]  = '{RCR, 8'h3C, 1'b1, 3'd0, 8'h3C, 1'b1};
    vecs[8]  = '{LSR, 8'h80, 1'b0, 3'd7, 8'h01, 1'b0};
    vecs[9]  = '{LSR, 8'hFF, 1'b0, 3'd7, 8'h01, 1'b1};
    vecs[10] = '{RCR, 8'hB5, 1'b1, 3'd3, 8'h76, 1'b1};
    vecs[11] = '{ASR, 8'h35, 1'b0, 3'd2, 8'h0D, 1'b0};

    rst_i        = 1'b1;
    valid_i      = 1'b0;
    ready_i      = 1'b0;
    word_i       = '0;
    cf_i         = 1'b0;
    shift_size_i = '0;
    mode_i       = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_word", 32'(word_o), 32'd0);
    chk("rst_cf", 32'(cf_o), 32'd0);
    rst_i = 1'b0;

    // valid_i low in IDLE: nothing happens
    repeat (3) @(negedge clk);
    chk("idle_hold_ready", 32'(ready_o), 32'd1);
    chk("idle_hold_valid", 32'(valid_o), 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i], i);
    end

    // Backpressure with stray request pulses during SHIFT and DONE.
    @(negedge clk);
    valid_i = 1'b1; word_i = 8'hB5; cf_i = 1'b0; mode_i = LSR; shift_size_i = 3'd3;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b1; word_i = 8'hFF; cf_i = 1'b1; mode_i = ASR; shift_size_i = 3'd0;
    repeat (3) @(negedge clk);       // now after edge 3: DONE
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid_c%0d", c), 32'(valid_o), 32'd1);
      chk($sformatf("bp_word_c%0d", c), 32'(word_o), 32'h16);
      chk($sformatf("bp_cf_c%0d", c), 32'(cf_o), 32'd1);
      @(negedge clk);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(ready_o), 32'd1);
    chk("bp_release_valid", 32'(valid_o), 32'd0);
    ready_i = 1'b0;
    @(negedge clk);
    chk("bp_after_idle", 32'(ready_o), 32'd1);

    // Reset at edge 2 of a shift-7 LSR abandons the operation.
    @(negedge clk);
    valid_i = 1'b1; word_i = 8'hFF; cf_i = 1'b1; mode_i = LSR; shift_size_i = 3'd7;
    @(posedge clk);                 // edge 0
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);                 // after edge 1
    rst_i = 1'b1;
    @(negedge clk);                 // after edge 2
    rst_i = 1'b0;
    chk("mid_rst_ready", 32'(ready_o), 32'd1);
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    chk("mid_rst_word", 32'(word_o), 32'd0);
    chk("mid_rst_cf", 32'(cf_o), 32'd0);
    ready_i = 1'b1;
    begin
      int stale;
      stale = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (valid_o !== 1'b0) stale++;
      end
      chk("mid_rst_no_stale_valid", 32'(stale), 32'd0);
    end
    ready_i = 1'b0;

    // Handshake still works after the abandoned operation.
    run_op(vecs[0], 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_shift_r_seq
`default_nettype wire
